// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Brief    : Two-port (fetch/data) arbiter in front of the single-port ROM
//            controller, with anti-starvation, MBIST lockout and watchdog.
// Revision : 1.0
// ============================================================================
module rom_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              rom_ready,
  input  logic              mbist_en,
  output logic              arb_idle
);

  localparam int c_tmo_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_tmo_w-1:0]    c_tmo_last  = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_owner, w_owner_nxt;   // 0 = fetch, 1 = data
  logic [c_tmo_w-1:0]    r_tmo_cnt, w_tmo_cnt_nxt;
  logic [c_starve_w-1:0] r_starve_cnt, w_starve_cnt_nxt;

  logic w_pend, w_resp, w_timeout, w_can_grant, w_starved;
  logic w_gnt_i, w_gnt_d, w_grant;

  assign w_pend      = (r_state == S_PEND);
  assign w_resp      = w_pend && rom_ready;
  assign w_timeout   = w_pend && !rom_ready && (r_tmo_cnt == c_tmo_last);
  // rst_n gates grants so every output sits at its reset value during reset
  assign w_can_grant = rst_n && !mbist_en && (!w_pend || rom_ready);
  assign w_starved   = (r_starve_cnt == c_starve_max);
  assign w_gnt_i     = w_can_grant && i_req && (!d_req || w_starved);
  assign w_gnt_d     = w_can_grant && d_req && !(i_req && w_starved);
  assign w_grant     = w_gnt_i || w_gnt_d;

  assign i_gnt    = w_gnt_i;
  assign d_gnt    = w_gnt_d;
  assign rom_req  = w_grant;
  assign rom_addr = w_gnt_i ? i_addr : (w_gnt_d ? d_addr : '0);
  assign arb_idle = !w_pend && !w_grant;

  assign i_rvalid = (w_resp || w_timeout) && !r_owner;
  assign i_err    = w_timeout && !r_owner;
  assign i_rdata  = (w_resp && !r_owner) ? rom_rdata : '0;
  assign d_rvalid = (w_resp || w_timeout) && r_owner;
  assign d_err    = w_timeout && r_owner;
  assign d_rdata  = (w_resp && r_owner) ? rom_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_tmo_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_starve_cnt_nxt = r_starve_cnt;

    if (w_grant) begin
      w_state_nxt   = S_PEND;
      w_owner_nxt   = w_gnt_d;
      w_tmo_cnt_nxt = '0;
    end else if (w_resp || w_timeout) begin
      w_state_nxt   = S_IDLE;
      w_tmo_cnt_nxt = '0;
    end else if (w_pend) begin
      w_tmo_cnt_nxt = r_tmo_cnt + c_tmo_w'(1);
    end

    // Starvation history is frozen while MBIST owns the ROM
    if (!mbist_en) begin
      if (!i_req || w_gnt_i) begin
        w_starve_cnt_nxt = '0;
      end else if (w_gnt_d && !w_starved) begin
        w_starve_cnt_nxt = r_starve_cnt + c_starve_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single-port ROM controller between two requesters: instruction fetch (port I) and data load (port D).
- Sits between the core's fetch/load units and rom_controller. Drives rom_req/rom_addr and routes rom_rdata/rom_ready back to the owning requester.
- Provides fixed priority with D preferred, an anti-starvation override for I, MBIST lockout, and a response watchdog.

Parameters:
- ADDR_W, 15, byte address width; matches rom_addr.
- DATA_W, 32, read data width.
- STARVE_LIMIT, 4, consecutive D grants while I is waiting before I is forced to win; must be >= 1.
- TIMEOUT, 16, cycles to wait for rom_ready before an error response; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch response data
- i_err  out  1  fetch error, valid with i_rvalid
- d_req  in  1  data request; held with d_addr until d_gnt
- d_addr  in  ADDR_W  data byte address
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid
- d_rdata  out  DATA_W  data response data
- d_err  out  1  data error, valid with d_rvalid
- rom_req  out  1  request to rom_controller
- rom_addr  out  ADDR_W  address to rom_controller
- rom_rdata  in  DATA_W  ROM read data
- rom_ready  in  1  ROM data valid; nominally 1 cycle after rom_req
- mbist_en  in  1  MBIST active; blocks new grants
- arb_idle  out  1  no request outstanding and no grant this cycle

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset values: pend_q=0, owner_q=0, starve_cnt=0, tmo_cnt=0. All outputs are 0 in reset except arb_idle=1.
- States: IDLE (pend_q=0) and PEND (pend_q=1, owner_q selects I or D).
- Grant window (can_grant): !mbist_en && (!pend_q || rom_ready). This allows back-to-back grants at 1 per cycle.
- Selection when can_grant:
  - Only one requester active: that requester wins.
  - Both active: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
- Grant outputs: i_gnt and d_gnt are combinational, one-hot, and never asserted outside can_grant.
- In a grant cycle: rom_req=1 and rom_addr=winner's address, passed through combinationally. Registers then load pend_q=1, owner_q=winner, tmo_cnt=0.
- rom_addr is 0 whenever rom_req=0.
- Response: when pend_q && rom_ready, the owner's rvalid=1 and rdata=rom_rdata (combinational pass-through), with err=0. The non-owner's rdata=0.
  - With no new grant in that cycle, pend_q clears.
  - With a simultaneous new grant, pend_q stays 1 and owner_q updates.
- Latency: with the ROM at 1-cycle latency, rvalid arrives exactly 1 cycle after gnt. Sustained throughput is 1 grant per cycle.
- Watchdog: tmo_cnt increments each cycle that pend_q && !rom_ready. When tmo_cnt reaches TIMEOUT-1 with still no rom_ready:
  - the owner gets rvalid=1, err=1, rdata=0;
  - pend_q clears;
  - no grant is issued in that cycle.
  - A late rom_ready that arrives while pend_q=0 is ignored.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on a D grant while i_req=1.
  - Clears on an I grant or whenever i_req=0.
- MBIST:
  - mbist_en=1 blocks new grants; a pending transaction still completes or times out.
  - Requests stay pending, since requesters hold req.
  - starve_cnt holds its value while mbist_en=1.
  - Deasserting mbist_en makes arbitration resume on the same cycle.
- arb_idle = !pend_q && !rom_req.
- Reset mid-operation: pending state is discarded, and no response is produced for the in-flight request. Requesters must re-issue.
- Addresses are not checked for alignment; rom_controller uses word indexing.

Test Plan:
- ROM preloaded with word[i]=0xDEAD_0000+i; i_req with i_addr=0x0010 -> i_gnt that cycle; next cycle i_rvalid=1, i_rdata=0xDEAD_0004, i_err=0, arb_idle then 1.
- i_req and d_req rise in the same cycle, i_addr=0x0000, d_addr=0x0100 -> d_gnt first, then i_gnt the following cycle; d_rdata=0xDEAD_0040, then i_rdata=0xDEAD_0000; no gap cycle between grants.
- d_req held high continuously with i_req high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...; starve_cnt returns to 0 after the I grant.
- mbist_en=1 for 50 cycles with i_req high -> no i_gnt and rom_req=0 throughout; mbist_en falls -> i_gnt on that cycle and data returns normally.
- ROM model holds rom_ready=0 after a d_gnt -> at the 16th cycle after the grant, d_rvalid=1, d_err=1, d_rdata=0; a late rom_ready produces no rvalid.
- rst_n asserted in the cycle after a grant, with rom_ready high -> no rvalid on either port; all outputs 0, arb_idle=1; after release, a fresh request completes normally.
